// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word holding register so a new word
// can be accepted while the previous one is still shifting out.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] shreg, hold, load_word;
  logic             hold_valid;
  logic [CW-1:0]    cnt;
  logic             accept, consume, finish, load;

  // in_ready depends only on registered state, never on out_ready
  assign in_ready  = !hold_valid;
  assign accept    = in_valid && !hold_valid;
  assign consume   = (state == SHIFT) && out_ready;
  assign finish    = consume && (cnt == LAST);
  assign load      = ((state == IDLE) || finish) && (hold_valid || accept);
  assign load_word = hold_valid ? hold : in_data;

  always_comb begin
    state_nx = state;
    if (load)        state_nx = SHIFT;
    else if (finish) state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg      <= '0;
      cnt        <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
    end else begin
      if (load) begin
        shreg <= load_word;
        cnt   <= '0;
      end else if (finish) begin
        shreg <= '0;
        cnt   <= '0;
      end else if (consume) begin
        shreg <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
        cnt   <= cnt + 1'b1;
      end
      // an accepted word that could not go straight into the shifter parks here
      if (accept && !load) begin
        hold       <= in_data;
        hold_valid <= 1'b1;
      end else if (load && hold_valid) begin
        hold_valid <= 1'b0;
      end
    end
  end

  assign out_valid = (state == SHIFT);
  assign out_last  = (state == SHIFT) && (cnt == LAST);
  assign out_bit   = (state == SHIFT) && (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
  assign busy      = (state == SHIFT) || hold_valid;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: three instances (8/MSB, 8/LSB, 2/MSB) checked every
// cycle against a bit-queue model, plus literal bitstream expectations.
module tb_bit_serializer;

  localparam int WD [3] = '{8, 8, 2};
  localparam bit MF [3] = '{1'b1, 1'b0, 1'b1};

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din [3];
  logic [2:0] iv, orr, ir, ob, ov, ol, bz;

  int n_chk  = 0;
  int n_fail = 0;
  bit armed  = 1'b0;

  // model: pending bits of every accepted word in transmit order
  bit q   [3][$];
  bit cap [3][$];

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_m8 (
    .clk(clk), .rst(rst), .in_data(din[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .out_bit(ob[0]), .out_valid(ov[0]), .out_ready(orr[0]), .out_last(ol[0]), .busy(bz[0]));
  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_l8 (
    .clk(clk), .rst(rst), .in_data(din[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .out_bit(ob[1]), .out_valid(ov[1]), .out_ready(orr[1]), .out_last(ol[1]), .busy(bz[1]));
  bit_serializer #(.WIDTH(2), .MSB_FIRST(1'b1)) u_m2 (
    .clk(clk), .rst(rst), .in_data(din[2][1:0]), .in_valid(iv[2]), .in_ready(ir[2]),
    .out_bit(ob[2]), .out_valid(ov[2]), .out_ready(orr[2]), .out_last(ol[2]), .busy(bz[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] capval(input int k, input int s, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++)
      v = {v[30:0], (s + i < cap[k].size()) ? cap[k][s + i] : 1'b1};
    return v;
  endfunction

  // compare outputs against the model, then advance the model across the next edge
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int sz;
      sz = q[k].size();
      if (armed) begin
        chk($sformatf("out_valid[%0d]", k), 32'(ov[k]), 32'(sz > 0));
        chk($sformatf("out_bit[%0d]", k),   32'(ob[k]), 32'((sz > 0) ? q[k][0] : 1'b0));
        chk($sformatf("out_last[%0d]", k),  32'(ol[k]), 32'((sz % WD[k]) == 1));
        chk($sformatf("in_ready[%0d]", k),  32'(ir[k]), 32'(sz <= WD[k]));
        chk($sformatf("busy[%0d]", k),      32'(bz[k]), 32'(sz > 0));
      end
      if (rst) begin
        q[k].delete();
      end else begin
        if (sz > 0 && orr[k]) cap[k].push_back(q[k].pop_front());
        if (iv[k] && sz <= WD[k])
          for (int i = 0; i < WD[k]; i++)
            q[k].push_back(MF[k] ? din[k][WD[k]-1-i] : din[k][i]);
      end
    end
    if (rst) armed = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s;
    rst = 1'b1; iv = '0; orr = '1;
    for (int k = 0; k < 3; k++) din[k] = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset out_valid", 32'(ov), 32'h0);
    chk("reset out_bit",   32'(ob), 32'h0);
    chk("reset out_last",  32'(ol), 32'h0);
    chk("reset busy",      32'(bz), 32'h0);
    chk("reset in_ready",  32'(ir), 32'h7);

    // single word B5, first bit the cycle after acceptance
    s = cap[0].size();
    din[0] = 8'hB5; iv[0] = 1'b1; tick(); iv[0] = 1'b0;
    chk("b5 latency", 32'(ov[0]), 32'h1);
    repeat (9) tick();
    chk("b5 stream", capval(0, s, 8), 32'hB5);
    chk("b5 idle after", 32'(ov[0]), 32'h0);

    // back-to-back B0, 0B: second word waits in hold
    s = cap[0].size();
    din[0] = 8'hB0; iv[0] = 1'b1; tick();
    din[0] = 8'h0B; tick(); iv[0] = 1'b0;
    chk("b2b hold ready", 32'(ir[0]), 32'h0);
    repeat (18) tick();
    chk("b2b stream", capval(0, s, 16), 32'hB00B);

    // stall three cycles on the first zero bit of F0
    s = cap[0].size();
    din[0] = 8'hF0; iv[0] = 1'b1; tick(); iv[0] = 1'b0;
    repeat (4) tick();
    orr[0] = 1'b0;
    repeat (3) begin
      chk("stall bit", 32'(ob[0]), 32'h0);
      tick();
    end
    orr[0] = 1'b1;
    repeat (8) tick();
    chk("stall stream", capval(0, s, 8), 32'hF0);

    // reset mid-word with hold full, handshake on the same edge is dropped
    din[0] = 8'hA5; iv[0] = 1'b1; tick();
    din[0] = 8'h3C; tick(); iv[0] = 1'b0;
    repeat (4) tick();
    rst = 1'b1; din[0] = 8'hFF; iv[0] = 1'b1; tick();
    rst = 1'b0; iv[0] = 1'b0;
    chk("rst out_valid", 32'(ov[0]), 32'h0);
    chk("rst busy",      32'(bz[0]), 32'h0);
    chk("rst in_ready",  32'(ir[0]), 32'h1);
    s = cap[0].size();
    din[0] = 8'hC3; iv[0] = 1'b1; tick(); iv[0] = 1'b0;
    repeat (9) tick();
    chk("post-rst stream", capval(0, s, 8), 32'hC3);

    // LSB-first: 0D goes out as 1,0,1,1,0,0,0,0
    s = cap[1].size();
    din[1] = 8'h0D; iv[1] = 1'b1; tick(); iv[1] = 1'b0;
    repeat (9) tick();
    chk("lsb stream", capval(1, s, 8), 32'hB0);

    // random traffic on all instances
    repeat (1000) begin
      for (int k = 0; k < 3; k++) begin
        iv[k]  = 1'($urandom_range(0, 1));
        din[k] = 8'($urandom);
        orr[k] = (k == 2) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) != 0);
      end
      tick();
    end
    iv = '0; orr = '1;
    repeat (30) tick();
    chk("drain out_valid", 32'(ov), 32'h0);
    chk("drain busy",      32'(bz), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
